counter_seq_checker: RTL and testbench
======================================

// Module: counter_seq_checker
// PURPOSE
//  Receive-side checker for the free-running incrementing 8-bit counter stream the chip emits.
//  Samples an incoming counter value on each in_valid and checks it is previous+1 (mod 2^WIDTH).
//  Acquires lock, tracks it, counts sequence errors while locked, and drops lock on repeated misses.
//  Sits on the bench/loopback side of the counter output pins; outputs feed status pins or a host read.
// PARAMETERS
//  WIDTH     8   bit width of sampled counter value
//  LOCK_CNT  4   consecutive correct increments needed to enter LOCKED (>=1)
//  LOSS_CNT  3   consecutive mismatches in LOCKED that force ACQUIRE (>=1)
//  ERR_W     16  width of saturating error counter
// PORTS
//  clk             in   1       clock, all logic on rising edge
//  rst             in   1       synchronous, active-high reset
//  in_valid        in   1       in_data holds a sample this cycle
//  in_data         in   WIDTH   sampled counter value
//  clear           in   1       sync clear of err_count (and first-error capture); FSM unaffected
//  locked          out  1       registered; 1 while FSM in LOCKED
//  err_pulse       out  1       registered; 1-cycle pulse per mismatch counted in LOCKED
//  err_count       out  ERR_W   registered; saturating count of counted mismatches
//  expected        out  WIDTH   registered; value the next sample must equal
//  first_err_valid out  1       first-error capture valid (0 without SEQ_CHK_FIRST_ERR_EN)
//  first_err_data  out  WIDTH   sample at first counted error (0 without macro)
//  first_err_exp   out  WIDTH   expected value at first counted error (0 without macro)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; locked=0, err_pulse=0, err_count=0, expected=0, first_err_*=0,
//   good_run=0, bad_run=0. Reset mid-stream discards all history; next sample restarts acquisition.
//  Latency: sample at edge N -> locked/err_pulse/err_count/expected updated after edge N (1 cycle).
//  in_valid=0: all state held, err_pulse=0; no timeout.
//  Compare: match iff in_data == expected; arithmetic mod 2^WIDTH (expected 0xFF, data 0x00 = match).
//  IDLE: on valid -> expected=in_data+1, good_run=0, go ACQUIRE.
//  ACQUIRE: match -> good_run++, expected++; if good_run+1==LOCK_CNT -> LOCKED, bad_run=0.
//   mismatch -> resync: expected=in_data+1, good_run=0; no error counted.
//  LOCKED: match -> bad_run=0, expected++.
//   mismatch -> err_pulse=1, err_count+=1 (saturate at all-ones), bad_run++, expected++ (flywheel,
//   no resync); if bad_run+1==LOSS_CNT -> ACQUIRE, expected=in_data+1, good_run=0.
//  clear and counted error same cycle: clear wins, err_count=0; err_pulse still asserted.
//  err_count at max: stays at max; err_pulse still fires.
// CONFIGURATION
//  SEQ_CHK_FIRST_ERR_EN defined: on first counted error after reset/clear, latch in_data, expected,
//   set first_err_valid=1; later errors leave capture unchanged; clear/rst zero it (clear+error same
//   cycle: error not captured).
//  Undefined: capture regs not built; first_err_valid/data/exp tied to 0.
// STRUCTURE
//  Package seq_chk_pkg: state enum typedef (IDLE, ACQUIRE, LOCKED), 2-bit encodings, default params.
//  Sub-module sat_counter (ERR_W, inc, clr, count; clr priority) for err_count.
//  Run counters sized $clog2(max(LOCK_CNT,LOSS_CNT))+1.
// TESTING
//  Reset, feed 0x10..0x14 valid each cycle -> locked=1 after 5th sample's edge, err_count=0.
//  Locked stream 0xFD,0xFE,0xFF,0x00,0x01 -> no err_pulse, locked stays 1 (wrap is a match).
//  Locked, expected 0x20, inject 0x55 once then 0x21 -> one err_pulse, err_count=1, locked=1.
//  Locked, 3 consecutive bad samples -> err_count=3, locked=0 after 3rd; 4 good -> locked=1.
//  In ACQUIRE, random jumps -> resync, err_count stays 0; in_valid gaps -> state held.
//  clear coincident with error -> err_count=0, err_pulse=1; with macro first_err_valid=0; rst mid-lock -> all 0.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// Shared state encoding and default parameters for the counter sequence checker.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } seq_state_t;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_LOSS_CNT = 3;
  localparam int unsigned DEF_ERR_W    = 16;

  function automatic int unsigned run_width(input int unsigned lock_cnt, input int unsigned loss_cnt);
    int unsigned m;
    m = (lock_cnt > loss_cnt) ? lock_cnt : loss_cnt;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side checker for an incrementing counter stream: acquires lock, counts misses while locked.
// Define SEQ_CHK_FIRST_ERR_EN to build the first-error capture registers.
module counter_seq_checker
  import seq_chk_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned LOSS_CNT = DEF_LOSS_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_data,
  output logic [WIDTH-1:0] first_err_exp
);

  localparam int unsigned RUN_W = run_width(LOCK_CNT, LOSS_CNT);

  seq_state_t       state, state_nx;
  logic [RUN_W-1:0] good_run, good_nx;
  logic [RUN_W-1:0] bad_run, bad_nx;
  logic [WIDTH-1:0] exp_nx;
  logic             match;
  logic             err_hit;

  assign match = (in_data == expected);

  always_comb begin
    state_nx = state;
    exp_nx   = expected;
    good_nx  = good_run;
    bad_nx   = bad_run;
    err_hit  = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          exp_nx   = in_data + 1'b1;
          good_nx  = '0;
          state_nx = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            good_nx = good_run + 1'b1;
            exp_nx  = expected + 1'b1;
            if ((good_run + 1'b1) == RUN_W'(LOCK_CNT)) begin
              state_nx = LOCKED;
              bad_nx   = '0;
            end
          end else begin
            exp_nx  = in_data + 1'b1;
            good_nx = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_nx = '0;
            exp_nx = expected + 1'b1;
          end else begin
            // Flywheel through isolated misses; only a full loss run resyncs to the stream.
            err_hit = 1'b1;
            bad_nx  = bad_run + 1'b1;
            exp_nx  = expected + 1'b1;
            if ((bad_run + 1'b1) == RUN_W'(LOSS_CNT)) begin
              state_nx = ACQUIRE;
              exp_nx   = in_data + 1'b1;
              good_nx  = '0;
              bad_nx   = '0;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      expected  <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      expected  <= exp_nx;
      good_run  <= good_nx;
      bad_run   <= bad_nx;
      locked    <= (state_nx == LOCKED);
      err_pulse <= err_hit;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_hit),
    .clr  (clear),
    .count(err_count)
  );

`ifdef SEQ_CHK_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      first_err_valid <= 1'b0;
      first_err_data  <= '0;
      first_err_exp   <= '0;
    end else if (err_hit && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_data  <= in_data;
      first_err_exp   <= expected;
    end
  end
`else
  assign first_err_valid = 1'b0;
  assign first_err_data  = '0;
  assign first_err_exp   = '0;
`endif

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed self-checking bench for counter_seq_checker (default parameters).
module tb_counter_seq_checker;
  import seq_chk_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        clear = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [7:0]  expected;
  logic        first_err_valid;
  logic [7:0]  first_err_data;
  logic [7:0]  first_err_exp;

  int checks = 0;
  int passed = 0;

`ifdef SEQ_CHK_FIRST_ERR_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  counter_seq_checker #(
    .WIDTH(8),
    .LOCK_CNT(4),
    .LOSS_CNT(3),
    .ERR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .clear(clear),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .expected(expected),
    .first_err_valid(first_err_valid),
    .first_err_data(first_err_data),
    .first_err_exp(first_err_exp)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) $display("FAIL %s: got %0h want %0h", name, got, want);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_pulse", 16'(err_pulse), 16'h0);
    chk("rst_count", err_count, 16'h0);
    chk("rst_expected", 16'(expected), 16'h0);
    chk("rst_fev", 16'(first_err_valid), 16'h0);
    chk("rst_fed", 16'(first_err_data), 16'h0);
  endtask

  // Lock from base: base..base+4 -> locked only after the fifth sample.
  task automatic acquire_from(input string tag, input logic [7:0] base, input bit verify);
    logic [7:0] d;
    for (int i = 0; i < 5; i++) begin
      d = base + 8'(i);
      drive(1'b1, d, 1'b0);
      if (verify) begin
        chk({tag, "_locked"}, 16'(locked), (i == 4) ? 16'h1 : 16'h0);
        chk({tag, "_exp"}, 16'(expected), 16'(8'(d + 8'h01)));
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    acquire_from("lock", 8'h10, 1'b1);
    chk("lock_count", err_count, 16'h0);
  endtask

  task automatic test_wrap();
    logic [7:0] seq [5];
    logic [7:0] nxt [5];
    seq = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    nxt = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    do_reset();
    acquire_from("wrapacq", 8'hF8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i], 1'b0);
      chk("wrap_pulse", 16'(err_pulse), 16'h0);
      chk("wrap_locked", 16'(locked), 16'h1);
      chk("wrap_exp", 16'(expected), 16'(nxt[i]));
    end
    chk("wrap_count", err_count, 16'h0);
  endtask

  task automatic test_single_err();
    do_reset();
    acquire_from("seacq", 8'h1B, 1'b0);
    chk("se_exp0", 16'(expected), 16'h20);
    drive(1'b1, 8'h55, 1'b0);
    chk("se_pulse", 16'(err_pulse), 16'h1);
    chk("se_count", err_count, 16'h1);
    chk("se_locked", 16'(locked), 16'h1);
    chk("se_exp", 16'(expected), 16'h21);
    chk("se_fev", 16'(first_err_valid), 16'(CAP));
    chk("se_fed", 16'(first_err_data), CAP ? 16'h55 : 16'h0);
    chk("se_fee", 16'(first_err_exp), CAP ? 16'h20 : 16'h0);
    drive(1'b1, 8'h21, 1'b0);
    chk("se_pulse2", 16'(err_pulse), 16'h0);
    chk("se_count2", err_count, 16'h1);
    chk("se_exp2", 16'(expected), 16'h22);
    // Gap cycles hold every piece of state.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'hAA, 1'b0);
      chk("gap_pulse", 16'(err_pulse), 16'h0);
      chk("gap_exp", 16'(expected), 16'h22);
      chk("gap_locked", 16'(locked), 16'h1);
      chk("gap_count", err_count, 16'h1);
    end
  endtask

  task automatic test_loss();
    logic [7:0] bad [3];
    logic [7:0] bexp [3];
    logic [7:0] good [4];
    bad  = '{8'h90, 8'h91, 8'h92};
    bexp = '{8'h46, 8'h47, 8'h93};
    good = '{8'h93, 8'h94, 8'h95, 8'h96};
    do_reset();
    acquire_from("lossacq", 8'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bad[i], 1'b0);
      chk("loss_pulse", 16'(err_pulse), 16'h1);
      chk("loss_count", err_count, 16'(i + 1));
      chk("loss_locked", 16'(locked), (i == 2) ? 16'h0 : 16'h1);
      chk("loss_exp", 16'(expected), 16'(bexp[i]));
    end
    chk("loss_fed", 16'(first_err_data), CAP ? 16'h90 : 16'h0);
    chk("loss_fee", 16'(first_err_exp), CAP ? 16'h45 : 16'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, good[i], 1'b0);
      chk("relock_locked", 16'(locked), (i == 3) ? 16'h1 : 16'h0);
      chk("relock_pulse", 16'(err_pulse), 16'h0);
    end
    chk("relock_exp", 16'(expected), 16'h97);
    chk("relock_count", err_count, 16'h3);
  endtask

  task automatic test_resync();
    logic       v    [9];
    logic [7:0] d    [9];
    logic [7:0] e    [9];
    logic       l    [9];
    v = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    d = '{8'h05, 8'h30, 8'h31, 8'h77, 8'hEE, 8'h78, 8'h79, 8'h7A, 8'h7B};
    e = '{8'h06, 8'h31, 8'h32, 8'h78, 8'h78, 8'h79, 8'h7A, 8'h7B, 8'h7C};
    l = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(v[i], d[i], 1'b0);
      chk("rs_exp", 16'(expected), 16'(e[i]));
      chk("rs_locked", 16'(locked), 16'(l[i]));
      chk("rs_pulse", 16'(err_pulse), 16'h0);
      chk("rs_count", err_count, 16'h0);
    end
  endtask

  // Continues from the locked state left by test_resync (expected 0x7C).
  task automatic test_clear();
    drive(1'b1, 8'h00, 1'b0);
    chk("clr_count0", err_count, 16'h1);
    chk("clr_fev0", 16'(first_err_valid), 16'(CAP));
    drive(1'b1, 8'h01, 1'b1);
    chk("clr_pulse", 16'(err_pulse), 16'h1);
    chk("clr_count", err_count, 16'h0);
    chk("clr_fev", 16'(first_err_valid), 16'h0);
    chk("clr_fed", 16'(first_err_data), 16'h0);
    chk("clr_locked", 16'(locked), 16'h1);
    chk("clr_exp", 16'(expected), 16'h7E);
    drive(1'b1, 8'h7E, 1'b0);
    chk("clr_pulse2", 16'(err_pulse), 16'h0);
    drive(1'b1, 8'h02, 1'b0);
    chk("clr_count2", err_count, 16'h1);
    chk("clr_fev2", 16'(first_err_valid), 16'(CAP));
    chk("clr_fed2", 16'(first_err_data), CAP ? 16'h02 : 16'h0);
    chk("clr_fee2", 16'(first_err_exp), CAP ? 16'h7F : 16'h0);
  endtask

  task automatic test_rst_mid();
    do_reset();
    chk("rm_locked", 16'(locked), 16'h0);
    chk("rm_count", err_count, 16'h0);
    chk("rm_exp", 16'(expected), 16'h0);
    chk("rm_fev", 16'(first_err_valid), 16'h0);
    drive(1'b1, 8'h50, 1'b0);
    chk("rm_exp2", 16'(expected), 16'h51);
    chk("rm_locked2", 16'(locked), 16'h0);
    chk("rm_pulse2", 16'(err_pulse), 16'h0);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_single_err();
    test_loss();
    test_resync();
    test_clear();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary want summary");
    $fatal(1);
  end

endmodule
